// File: rtl/m_pipe_accumulator_pkg.sv
// Shared definitions for the multiply-adder pipe accumulator: pipe latency,
// accumulator width default and FSM state encodings.
package m_pipe_accumulator_pkg;

    localparam int MUL_PIPE_LATENCY  = 3;
    localparam int ACC_WIDTH_DEFAULT = 40;
    localparam int Y_WIDTH           = 32;
    localparam int CNT_WIDTH         = 8;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

endpackage

// File: rtl/m_valid_delay.sv
// Depth-parameterised 1-bit shift register that tracks operand validity
// alongside the multiply-adder pipe; synchronous active-low clear.
module m_valid_delay
    import m_pipe_accumulator_pkg::*;
#(
    parameter int P_DEPTH = MUL_PIPE_LATENCY
) (
    input  logic w_clock,
    input  logic w_reset_n,
    input  logic w_in,
    output logic r_tap
);

    logic [P_DEPTH-1:0] r_chain;

    generate
        if (P_DEPTH == 1) begin : g_single
            always_ff @(posedge w_clock) begin
                if (!w_reset_n) r_chain <= '0;
                else            r_chain <= w_in;
            end
        end else begin : g_chain
            always_ff @(posedge w_clock) begin
                if (!w_reset_n) r_chain <= '0;
                else            r_chain <= {r_chain[P_DEPTH-2:0], w_in};
            end
        end
    endgenerate

    assign r_tap = r_chain[P_DEPTH-1];

endmodule

// File: rtl/m_pipe_accumulator.sv
// Sums P_COUNT consecutive valid pipe results into a frame and presents the
// frame sum on a valid/ready output; the input side never stalls.
module m_pipe_accumulator
    import m_pipe_accumulator_pkg::*;
#(
    parameter int P_LATENCY   = MUL_PIPE_LATENCY,
    parameter int P_COUNT     = 4,
    parameter int P_ACC_WIDTH = ACC_WIDTH_DEFAULT
) (
    input  logic                   w_clock,
    input  logic                   w_reset_n,
    input  logic                   w_in_valid,
    input  logic [Y_WIDTH-1:0]     w_y,
    input  logic                   w_flush,
    input  logic                   w_sum_ready,
    output logic [P_ACC_WIDTH-1:0] r_sum,
    output logic [CNT_WIDTH-1:0]   r_sum_cnt,
    output logic                   r_sum_valid,
    output logic                   r_overflow,
    output logic                   r_busy
);

    // Handshake: a frame transfers on a posedge where r_sum_valid & w_sum_ready;
    // r_sum/r_sum_cnt hold stable while r_sum_valid is high and not accepted.

    localparam logic [CNT_WIDTH-1:0] LP_COUNT = CNT_WIDTH'(P_COUNT);

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   w_y_valid;
    logic [P_ACC_WIDTH-1:0] r_acc;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [P_ACC_WIDTH-1:0] w_sum_in;
    logic [CNT_WIDTH-1:0]   w_cnt_in;
    logic                   w_emit;
    logic                   w_slot_free;

    m_valid_delay #(
        .P_DEPTH (P_LATENCY)
    ) u_valid_delay (
        .w_clock   (w_clock),
        .w_reset_n (w_reset_n),
        .w_in      (w_in_valid),
        .r_tap     (w_y_valid)
    );

    always_ff @(posedge w_clock) begin
        if (!w_reset_n) r_state <= S_IDLE;
        else            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_y_valid && !w_flush) w_next_state = S_ACCUM;
            S_ACCUM: if (w_emit)                w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // acc/cnt are zero in S_IDLE, so one add path covers both states.
    always_comb begin
        w_sum_in = r_acc;
        w_cnt_in = r_cnt;
        if (w_y_valid) begin
            w_sum_in = r_acc + {{(P_ACC_WIDTH-Y_WIDTH){1'b0}}, w_y};
            w_cnt_in = r_cnt + 1'b1;
        end
        w_emit = (w_y_valid && (w_cnt_in == LP_COUNT))
              || (w_flush && (w_cnt_in != '0));
    end

    always_ff @(posedge w_clock) begin
        if (!w_reset_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_emit) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else begin
            r_acc <= w_sum_in;
            r_cnt <= w_cnt_in;
        end
    end

    assign w_slot_free = !r_sum_valid || w_sum_ready;

    always_ff @(posedge w_clock) begin
        if (!w_reset_n) begin
            r_sum       <= '0;
            r_sum_cnt   <= '0;
            r_sum_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_emit && w_slot_free) begin
                r_sum       <= w_sum_in;
                r_sum_cnt   <= w_cnt_in;
                r_sum_valid <= 1'b1;
            end else if (w_sum_ready) begin
                r_sum_valid <= 1'b0;
            end
            if (w_emit && !w_slot_free) r_overflow <= 1'b1;
        end
    end

    assign r_busy = (r_state == S_ACCUM);

endmodule
